sao_stat_seq: RTL

Per-CTU sequencer for the SAO statistics accumulator bank. It counts incoming 4-pixel blocks, refreshes the accumulators at CTU start, and gates accumulation with not_end/wait_forPre/en_o. After the last block it drains the accumulator pipeline, then freezes and presents the per-CTU sums to the offset-decision stage through a valid/ack handshake. One instance drives every accumulator lane of a CTU; all control outputs fan out unchanged.

---
 rtl/sao_stat_seq.sv | 101 ++++++++++
 1 files changed

// File: rtl/sao_stat_seq.sv
// Per-CTU control sequencer for the SAO statistics accumulator bank.
// Counts 4-pixel blocks, refreshes at CTU start, drains the pipe, then holds the sums for the consumer.
module sao_stat_seq #(
  parameter int num_blk_in_CTB_log2 = 10,
  parameter int drain_lat           = 2
) (
  input  logic                           clk,
  input  logic                           arst_n,
  input  logic                           rst_n,
  input  logic                           ctu_start,
  output logic                           ctu_start_rdy,
  input  logic                           blk_valid,
  output logic                           blk_ready,
  output logic [num_blk_in_CTB_log2-1:0] blk_cnt,
  output logic                           en_o,
  output logic                           isToRefresh,
  output logic                           not_end,
  output logic                           wait_forPre,
  output logic                           stat_valid,
  input  logic                           stat_ack
);

  localparam int DW = (drain_lat > 1) ? $clog2(drain_lat) : 1;
  localparam logic [DW-1:0] DRAIN_LAST = DW'(drain_lat - 1);

  typedef enum logic [2:0] {IDLE, REFRESH, ACCU, DRAIN, HOLD} state_t;

  state_t        state, state_nxt;
  logic [DW-1:0] drain_cnt;
  logic          xfer;
  logic          last_blk;

  assign xfer     = (state == ACCU) && blk_valid;
  assign last_blk = xfer && (&blk_cnt);

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state     <= IDLE;
      blk_cnt   <= '0;
      drain_cnt <= '0;
    end else if (!rst_n) begin
      state     <= IDLE;
      blk_cnt   <= '0;
      drain_cnt <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        REFRESH: blk_cnt <= '0;
        ACCU: begin
          // The last transfer wraps the counter to 0 by natural overflow.
          if (xfer)     blk_cnt   <= blk_cnt + 1'b1;
          if (last_blk) drain_cnt <= '0;
        end
        DRAIN:   drain_cnt <= drain_cnt + 1'b1;
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nxt     = state;
    ctu_start_rdy = 1'b0;
    blk_ready     = 1'b0;
    en_o          = 1'b0;
    isToRefresh   = 1'b0;
    not_end       = 1'b0;
    wait_forPre   = 1'b1;
    stat_valid    = 1'b0;
    case (state)
      IDLE: begin
        ctu_start_rdy = 1'b1;
        if (ctu_start) state_nxt = REFRESH;
      end
      REFRESH: begin
        en_o        = 1'b1;
        isToRefresh = 1'b1;
        state_nxt   = ACCU;
      end
      ACCU: begin
        en_o        = 1'b1;
        not_end     = 1'b1;
        blk_ready   = 1'b1;
        // Bubble cycles must not add stale partial sums.
        wait_forPre = !blk_valid;
        if (last_blk) state_nxt = DRAIN;
      end
      DRAIN: begin
        en_o = 1'b1;
        if (drain_cnt == DRAIN_LAST) state_nxt = HOLD;
      end
      HOLD: begin
        // en_o stays low so the sums stay frozen while presented.
        stat_valid    = 1'b1;
        ctu_start_rdy = stat_ack;
        if (stat_ack) state_nxt = ctu_start ? REFRESH : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule
